// File: rtl/cp0_regfile_pkg.sv
// cp0_regfile_pkg: CP0 register addresses, exception codes and flag positions
package cp0_regfile_pkg;
  localparam logic [7:0] CP0_BADVADDR = 8'h40;
  localparam logic [7:0] CP0_COUNT = 8'h48;
  localparam logic [7:0] CP0_COMPARE = 8'h58;
  localparam logic [7:0] CP0_STATUS = 8'h60;
  localparam logic [7:0] CP0_CAUSE = 8'h68;
  localparam logic [7:0] CP0_EPC = 8'h70;
  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_BP = 5'd9;
  localparam logic [4:0] EXC_RI = 5'd10;
  localparam logic [4:0] EXC_OV = 5'd12;
  localparam int EB_INT = 0;
  localparam int EB_ADEL = 1;
  localparam int EB_ADES = 2;
  localparam int EB_SYS = 3;
  localparam int EB_BP = 4;
  localparam int EB_RI = 5;
  localparam int EB_OV = 6;
  localparam logic [31:0] EXC_ENTRY_VEC = 32'hBFC0_0380;
  // Lowest set flag bit has the highest priority
  function automatic logic [4:0] exc_code(input logic [6:0] t);
    return t[EB_INT] ? EXC_INT :
           t[EB_ADEL] ? EXC_ADEL :
           t[EB_ADES] ? EXC_ADES :
           t[EB_SYS] ? EXC_SYS :
           t[EB_BP] ? EXC_BP :
           t[EB_RI] ? EXC_RI : EXC_OV;
  endfunction
endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: Count/Compare timer with half-rate Count and timer interrupt flag
module cp0_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        count_wen,
  input  logic        compare_wen,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);
  logic tick;
  // Count advances on every other cycle; a Count write overrides the increment
  always_ff @(posedge clk) begin
    if (reset) begin
      tick <= 1'b0;
      count <= 32'd0;
    end else begin
      tick <= ~tick;
      count <= count_wen ? wdata : count + {31'd0, tick};
    end
  end
  // Compare write clears TI, beating a same-cycle match
  always_ff @(posedge clk) begin
    if (reset) begin
      compare <= 32'd0;
      ti <= 1'b0;
    end else begin
      if (compare_wen) compare <= wdata;
      ti <= compare_wen ? 1'b0 : ti | (count == compare);
    end
  end
endmodule

// File: rtl/cp0_regfile.sv
// cp0_regfile: CP0 Status/Cause/EPC/BadVAddr registers, exception and ERET control
module cp0_regfile
  import cp0_regfile_pkg::*;
#(
  parameter logic [31:0] EXC_ENTRY = EXC_ENTRY_VEC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ws_valid,
  input  logic [7:0]  cp0_addr,
  input  logic        cp0_wen,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  input  logic [6:0]  exc_type,
  input  logic [31:0] pc,
  input  logic        is_slot,
  input  logic [31:0] bad_vaddr,
  input  logic [5:0]  hw_int,
  input  logic        eret,
  output logic [31:0] epc,
  output logic        int_happen,
  output logic        exc_flush,
  output logic        eret_flush,
  output logic [31:0] exc_pc
);
  logic [31:0] badvaddr, count, compare, status_rd, cause_rd;
  logic [7:0] im;
  logic [5:0] ip_hi;
  logic [1:0] ip_sw;
  logic [4:0] exccode, code;
  logic exl, ie, bd, ti, wen_ok;
  assign exc_flush = ws_valid & |exc_type;
  assign eret_flush = ws_valid & eret & ~exc_flush;
  assign wen_ok = ws_valid & cp0_wen & ~exc_flush;
  assign code = exc_code(exc_type);
  assign exc_pc = exc_flush ? EXC_ENTRY : epc;
  assign status_rd = {9'd0, 1'b1, 6'd0, im, 6'd0, exl, ie};
  assign cause_rd = {bd, ti, 14'd0, ip_hi, ip_sw, 1'b0, exccode, 2'b00};
  assign int_happen = |({ip_hi, ip_sw} & im) & ie & ~exl;
  cp0_timer u_timer (
    .clk(clk),
    .reset(reset),
    .count_wen(wen_ok && cp0_addr == CP0_COUNT),
    .compare_wen(wen_ok && cp0_addr == CP0_COMPARE),
    .wdata(cp0_wdata),
    .count(count),
    .compare(compare),
    .ti(ti)
  );
  // Status: MTC0 fields, then exception sets EXL or ERET clears it (later assignment wins)
  always_ff @(posedge clk) begin
    if (reset) begin
      im <= 8'd0;
      exl <= 1'b0;
      ie <= 1'b0;
    end else begin
      if (wen_ok && cp0_addr == CP0_STATUS) begin
        im <= cp0_wdata[15:8];
        exl <= cp0_wdata[1];
        ie <= cp0_wdata[0];
      end
      if (exc_flush) exl <= 1'b1;
      else if (eret_flush) exl <= 1'b0;
    end
  end
  // Cause: hardware IP sampled every cycle, software IP via MTC0, BD/ExcCode on exception
  always_ff @(posedge clk) begin
    if (reset) begin
      ip_hi <= 6'd0;
      ip_sw <= 2'd0;
      bd <= 1'b0;
      exccode <= 5'd0;
    end else begin
      ip_hi <= {hw_int[5] | ti, hw_int[4:0]};
      if (wen_ok && cp0_addr == CP0_CAUSE) ip_sw <= cp0_wdata[9:8];
      if (exc_flush) exccode <= code;
      if (exc_flush && !exl) bd <= is_slot;
    end
  end
  // EPC records the restart PC only for the first exception of a nest
  always_ff @(posedge clk) begin
    if (reset) epc <= 32'd0;
    else if (exc_flush && !exl) epc <= is_slot ? pc - 32'd4 : pc;
    else if (wen_ok && cp0_addr == CP0_EPC) epc <= cp0_wdata;
  end
  // BadVAddr captures the faulting address for address-error exceptions
  always_ff @(posedge clk) begin
    if (reset) badvaddr <= 32'd0;
    else if (exc_flush && (code == EXC_ADEL || code == EXC_ADES)) badvaddr <= bad_vaddr;
  end
  // Combinational read of pre-update register values
  always_comb begin
    cp0_rdata = cp0_addr == CP0_BADVADDR ? badvaddr :
                cp0_addr == CP0_COUNT ? count :
                cp0_addr == CP0_COMPARE ? compare :
                cp0_addr == CP0_STATUS ? status_rd :
                cp0_addr == CP0_CAUSE ? cause_rd :
                cp0_addr == CP0_EPC ? epc : 32'd0;
  end
endmodule

// File: tb/tb_cp0_regfile.sv
// tb_cp0_regfile: scoreboard bench for cp0_regfile against a register-level reference model
module tb_cp0_regfile;
  logic clk = 0, reset = 1, ws_valid = 0, cp0_wen = 0, is_slot = 0, eret = 0;
  logic [7:0] cp0_addr = 0;
  logic [31:0] cp0_wdata = 0, pc = 0, bad_vaddr = 0;
  logic [6:0] exc_type = 0;
  logic [5:0] hw_int = 0;
  logic [31:0] cp0_rdata, epc, exc_pc;
  logic int_happen, exc_flush, eret_flush;
  typedef struct {
    logic [31:0] rdata, epc, exc_pc;
    logic ih, ef, erf;
  } exp_t;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0;
  int codes[7] = '{0, 4, 5, 8, 9, 10, 12};
  logic [7:0] addrs[8] = '{8'h40, 8'h48, 8'h58, 8'h60, 8'h68, 8'h70, 8'h00, 8'h44};
  logic [31:0] m_badv, m_count, m_cmp, m_status, m_cause, m_epc;
  logic m_tick, m_ti;

  cp0_regfile dut (
    .clk(clk), .reset(reset), .ws_valid(ws_valid), .cp0_addr(cp0_addr),
    .cp0_wen(cp0_wen), .cp0_wdata(cp0_wdata), .cp0_rdata(cp0_rdata),
    .exc_type(exc_type), .pc(pc), .is_slot(is_slot), .bad_vaddr(bad_vaddr),
    .hw_int(hw_int), .eret(eret), .epc(epc), .int_happen(int_happen),
    .exc_flush(exc_flush), .eret_flush(eret_flush), .exc_pc(exc_pc)
  );

  always #5 clk = ~clk;

  function automatic void m_reset();
    m_badv = 0; m_count = 0; m_cmp = 0; m_status = 32'h0040_0000;
    m_cause = 0; m_epc = 0; m_tick = 0; m_ti = 0;
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", n, a, e, $time);
    end
  endtask

  // One clock of stimulus: push the expected response, then advance the model
  task automatic cyc();
    logic [31:0] crd, rd;
    logic exv, wc, old_exl, hit;
    int sel;
    exp_t e;
    if (reset) m_reset();
    else begin
      crd = m_cause | {1'b0, m_ti, 30'd0};
      case (cp0_addr)
        8'h40: rd = m_badv;
        8'h48: rd = m_count;
        8'h58: rd = m_cmp;
        8'h60: rd = m_status;
        8'h68: rd = crd;
        8'h70: rd = m_epc;
        default: rd = 0;
      endcase
      exv = ws_valid && exc_type != 0;
      sel = 6;
      for (int i = 6; i >= 0; i--) if (exc_type[i]) sel = i;
      e.rdata = rd;
      e.epc = m_epc;
      e.ih = (crd[15:8] & m_status[15:8]) != 0 && m_status[0] && !m_status[1];
      e.ef = exv;
      e.erf = ws_valid && eret && !exv;
      e.exc_pc = exv ? 32'hBFC0_0380 : m_epc;
      q.push_back(e);
      wc = ws_valid && cp0_wen && !exv;
      old_exl = m_status[1];
      hit = m_count == m_cmp;
      m_ti = (wc && cp0_addr == 8'h58) ? 1'b0 : (m_ti || hit);
      m_count = (wc && cp0_addr == 8'h48) ? cp0_wdata : m_count + (m_tick ? 1 : 0);
      m_tick = !m_tick;
      if (wc && cp0_addr == 8'h58) m_cmp = cp0_wdata;
      if (wc && cp0_addr == 8'h60) m_status = (cp0_wdata & 32'h0000_FF03) | 32'h0040_0000;
      if (exv) m_status = m_status | 32'h2;
      else if (e.erf) m_status = m_status & ~32'h2;
      m_cause[15:10] = {hw_int[5] | crd[30], hw_int[4:0]};
      if (wc && cp0_addr == 8'h68) m_cause[9:8] = cp0_wdata[9:8];
      if (exv) m_cause[6:2] = 5'(codes[sel]);
      if (exv && !old_exl) m_cause[31] = is_slot;
      if (exv && !old_exl) m_epc = is_slot ? pc - 4 : pc;
      else if (wc && cp0_addr == 8'h70) m_epc = cp0_wdata;
      if (exv && (sel == 1 || sel == 2)) m_badv = bad_vaddr;
    end
    @(negedge clk);
  endtask

  task automatic mtc0(input logic [7:0] a, input logic [31:0] d);
    ws_valid = 1; cp0_wen = 1; cp0_addr = a; cp0_wdata = d;
    cyc();
    ws_valid = 0; cp0_wen = 0;
  endtask

  task automatic rd(input logic [7:0] a);
    cp0_addr = a;
    cyc();
  endtask

  task automatic exc(input logic [6:0] t, input logic [31:0] p, input logic s);
    ws_valid = 1; exc_type = t; pc = p; is_slot = s;
    cyc();
    ws_valid = 0; exc_type = 0; is_slot = 0;
  endtask

  task automatic do_eret();
    ws_valid = 1; eret = 1;
    cyc();
    ws_valid = 0; eret = 0;
  endtask

  // Monitor: compare each cycle's outputs against the queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rdata", cp0_rdata, e.rdata);
        chk("epc", epc, e.epc);
        chk("exc_pc", exc_pc, e.exc_pc);
        chk("int_happen", 32'(int_happen), 32'(e.ih));
        chk("exc_flush", 32'(exc_flush), 32'(e.ef));
        chk("eret_flush", 32'(eret_flush), 32'(e.erf));
      end
    end
  end

  initial begin
    repeat (3) cyc();
    reset = 0;
    rd(8'h60); rd(8'h68); rd(8'h48);
    repeat (10) rd(8'h48);
    exc(7'b000_1000, 32'hBFC0_0100, 0);
    rd(8'h70); rd(8'h68); rd(8'h60);
    do_eret();
    rd(8'h60);
    bad_vaddr = 32'h1234_5671;
    exc(7'b000_0010, 32'h8000_0010, 1);
    rd(8'h70); rd(8'h68); rd(8'h40);
    exc(7'b100_0000, 32'h8000_0100, 0);
    rd(8'h70); rd(8'h68);
    do_eret();
    ws_valid = 1; cp0_wen = 1; cp0_addr = 8'h70; cp0_wdata = 32'hDEAD_BEEF;
    exc(7'b010_1000, 32'h8000_1000, 0);
    cp0_wen = 0;
    rd(8'h70); rd(8'h68);
    do_eret();
    mtc0(8'h48, 0); mtc0(8'h58, 4); mtc0(8'h60, 32'h0000_8001);
    repeat (14) rd(8'h68);
    mtc0(8'h58, 32'd1000);
    repeat (3) rd(8'h68);
    hw_int = 6'b000100;
    mtc0(8'h60, 32'h0000_1001);
    repeat (3) rd(8'h68);
    mtc0(8'h60, 32'h0000_1003);
    rd(8'h60); rd(8'h68);
    mtc0(8'h68, 32'h0000_0300);
    rd(8'h68);
    reset = 1; cyc(); reset = 0;
    rd(8'h60); rd(8'h68); rd(8'h70);
    for (int n = 0; n < 2500; n++) begin
      reset = $urandom_range(0, 399) == 0;
      ws_valid = $urandom_range(0, 3) != 0;
      exc_type = $urandom_range(0, 9) == 0 ? 7'($urandom) : 7'd0;
      eret = $urandom_range(0, 9) == 0;
      cp0_wen = $urandom_range(0, 2) == 0;
      cp0_addr = addrs[$urandom_range(0, 7)];
      cp0_wdata = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 40)) : $urandom;
      pc = $urandom & ~32'd3;
      is_slot = $urandom_range(0, 1) == 1;
      bad_vaddr = $urandom;
      if ($urandom_range(0, 15) == 0) hw_int = 6'($urandom);
      cyc();
    end
    reset = 0; ws_valid = 0; cp0_wen = 0; exc_type = 0; eret = 0;
    repeat (2) @(negedge clk);
    #3;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
